// File: rtl/bird_location_unit_if.sv
// Bird position bus: game tick and buttons in, bird coordinates out.
// The frame/tick side drives as master; the position tracker is the slave.
interface bird_location_unit_if;
    logic        bird_move;
    logic [3:0]  KEY;
    logic [10:0] bird_x;
    logic [10:0] bird_y;

    modport master (output bird_move, KEY, input  bird_x, bird_y);
    modport slave  (input  bird_move, KEY, output bird_x, bird_y);
endinterface

// File: rtl/bird_location_unit.sv
// Player bird position tracker: one saturating up/down step per bird_move rising edge.
// Latency: bird_y registered on the tick edge; KEY[3] adds 2 clk of sync. No backpressure.
// BIRD_GRAVITY_EN selects accelerating fall (velocity register) over constant FALL_STEP.
module bird_location_unit #(
    parameter int BIRD_X    = 100,
    parameter int Y_START   = 240,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 464,
    parameter int RISE_STEP = 4,
    parameter int FALL_STEP = 2,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 8
) (
    input  logic                  clk,
    input  logic                  RESET_GAME,
    bird_location_unit_if.slave   bus
);

    localparam logic [10:0] BIRD_X_C  = 11'(BIRD_X);
    localparam logic [10:0] Y_START_C = 11'(Y_START);
    localparam logic [10:0] Y_MIN_C   = 11'(Y_MIN);
    localparam logic [10:0] Y_MAX_C   = 11'(Y_MAX);
    localparam logic [10:0] RISE_C    = 11'(RISE_STEP);
    localparam logic [11:0] RISE_LIM  = 12'(Y_MIN + RISE_STEP);
    localparam logic [11:0] Y_MAX_W   = 12'(Y_MAX);

    logic        key_s1_q, key_s2_q;
    logic        move_q;
    logic [10:0] bird_y_q, bird_y_d;
    logic        tick, flap;
    logic [11:0] y_ext, fall_sum;
    logic        unused_keys;

    assign unused_keys = ^bus.KEY[2:0];
    assign tick        = bus.bird_move & ~move_q;
    assign flap        = ~key_s2_q;
    assign y_ext       = {1'b0, bird_y_q};

    always_ff @(posedge clk or negedge RESET_GAME) begin
        if (!RESET_GAME) begin
            key_s1_q <= 1'b1;
            key_s2_q <= 1'b1;
            move_q   <= 1'b0;
            bird_y_q <= Y_START_C;
        end else begin
            key_s1_q <= bus.KEY[3];
            key_s2_q <= key_s1_q;
            move_q   <= bus.bird_move;
            bird_y_q <= bird_y_d;
        end
    end

`ifdef BIRD_GRAVITY_EN
    logic [4:0] vel_q, vel_d, vel_fall;
    logic [5:0] vel_inc;

    assign vel_inc  = {1'b0, vel_q} + 6'(GRAVITY);
    assign vel_fall = (vel_inc > 6'(MAX_FALL)) ? 5'(MAX_FALL) : vel_inc[4:0];
    assign fall_sum = y_ext + {7'b0, vel_fall};

    // Velocity keeps building while pinned at the floor; only a flap or reset clears it.
    always_comb begin
        vel_d = vel_q;
        if (tick) begin
            vel_d = flap ? 5'd0 : vel_fall;
        end
    end

    always_ff @(posedge clk or negedge RESET_GAME) begin
        if (!RESET_GAME) begin
            vel_q <= 5'd0;
        end else begin
            vel_q <= vel_d;
        end
    end
`else
    assign fall_sum = y_ext + 12'(FALL_STEP);
`endif

    // 12-bit compares keep the 11-bit coordinate from wrapping at either limit.
    always_comb begin
        bird_y_d = bird_y_q;
        if (tick) begin
            if (flap) begin
                if (y_ext < RISE_LIM) begin
                    bird_y_d = Y_MIN_C;
                end else begin
                    bird_y_d = bird_y_q - RISE_C;
                end
            end else if (fall_sum > Y_MAX_W) begin
                bird_y_d = Y_MAX_C;
            end else begin
                bird_y_d = fall_sum[10:0];
            end
        end
    end

    assign bus.bird_x = BIRD_X_C;
    assign bus.bird_y = bird_y_q;

endmodule

// File: tb/tb_bird_location_unit.sv
// Scoreboard bench for bird_location_unit against a plain-arithmetic position model.
module tb_bird_location_unit;

    logic clk = 1'b0;
    logic RESET_GAME;

    bird_location_unit_if bif ();

    bird_location_unit dut (
        .clk        (clk),
        .RESET_GAME (RESET_GAME),
        .bus        (bif)
    );

    always #10 clk = ~clk;

`ifdef BIRD_GRAVITY_EN
    localparam int FALL5_Y   = 255;
    localparam int REL_FALL_Y = 241;
`else
    localparam int FALL5_Y   = 250;
    localparam int REL_FALL_Y = 242;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int m_y = 240;
    int m_v = 0;
    bit prev_move = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: position clamps to [0,464]; flap rises 4, fall is 2 or accelerating.
    task automatic model_tick(input bit flap);
        if (flap) begin
            m_y = (m_y - 4 < 0) ? 0 : m_y - 4;
            m_v = 0;
        end else begin
`ifdef BIRD_GRAVITY_EN
            m_v = (m_v + 1 > 8) ? 8 : m_v + 1;
            m_y = m_y + m_v;
`else
            m_y = m_y + 2;
`endif
            if (m_y > 464) m_y = 464;
        end
        exp_q.push_back(m_y);
    endtask

    task automatic do_tick(input bit flap, input int low_cyc, input int high_cyc);
        @(negedge clk);
        bif.KEY[3]    = ~flap;
        bif.bird_move = 1'b0;
        repeat (low_cyc) @(negedge clk);
        model_tick(flap);
        bif.bird_move = 1'b1;
        repeat (high_cyc) @(negedge clk);
        bif.bird_move = 1'b0;
    endtask

    task automatic apply_reset(input string name);
        @(negedge clk);
        #3 RESET_GAME = 1'b0;
        #1;
        chk(name, bif.bird_y, 240);
        chk({name, "_x"}, bif.bird_x, 100);
        m_y = 240;
        m_v = 0;
        #3 RESET_GAME = 1'b1;
    endtask

    // Monitor: detects each tick edge independently and pops the expected position.
    initial begin
        forever begin
            @(posedge clk);
            if (RESET_GAME && bif.bird_move && !prev_move) begin
                prev_move = 1'b1;
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tick_unexpected actual_y=%0d required=no_tick at %0t", bif.bird_y, $time);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("tick_y", bif.bird_y, e);
                    chk("tick_x", bif.bird_x, 100);
                end
            end else begin
                prev_move = RESET_GAME ? bif.bird_move : 1'b0;
            end
        end
    end

    always @(negedge RESET_GAME) prev_move = 1'b0;

    initial begin
        RESET_GAME    = 1'b0;
        bif.bird_move = 1'b0;
        bif.KEY       = 4'hF;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bif.bird_move = 1'($urandom_range(0, 1));
            bif.KEY       = 4'($urandom);
            #1;
            chk("rst_hold_y", bif.bird_y, 240);
            chk("rst_hold_x", bif.bird_x, 100);
        end
        @(negedge clk);
        bif.bird_move = 1'b0;
        bif.KEY       = 4'hF;
        RESET_GAME    = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_release_y", bif.bird_y, 240);

        for (int i = 0; i < 3; i++) do_tick(1'b1, 12, 12);
        chk("flap3_y", bif.bird_y, 228);

        apply_reset("midrun_rst_y");
        do_tick(1'b1, 6, 3);
        chk("after_rst_y", bif.bird_y, 236);

        apply_reset("fall_rst_y");
        for (int i = 0; i < 5; i++) do_tick(1'b0, 6, 3);
        chk("fall5_y", bif.bird_y, FALL5_Y);

        apply_reset("top_rst_y");
        for (int i = 0; i < 65; i++) do_tick(1'b1, 5, 2);
        chk("top_sat_y", bif.bird_y, 0);

        apply_reset("bot_rst_y");
        for (int i = 0; i < 150; i++) do_tick(1'b0, 5, 2);
        chk("bottom_sat_y", bif.bird_y, 464);

        apply_reset("edge_rst_y");
        do_tick(1'b1, 6, 100);
        chk("edge_only_y", bif.bird_y, 236);

        // Short KEY[3] release lying between clock edges must not reach the synchroniser.
        repeat (6) @(negedge clk);
        @(posedge clk);
        #3  bif.KEY[3] = 1'b1;
        #10 bif.KEY[3] = 1'b0;
        @(negedge clk);
        chk("glitch_hold_y", bif.bird_y, 236);
        model_tick(1'b1);
        bif.bird_move = 1'b1;
        repeat (3) @(negedge clk);
        bif.bird_move = 1'b0;
        chk("glitch_flap_y", bif.bird_y, 232);

        // bird_move already high when reset releases: first edge is a (non-flap) tick.
        @(negedge clk);
        #3 RESET_GAME = 1'b0;
        bif.KEY       = 4'hF;
        bif.bird_move = 1'b1;
        #1 chk("rel_tick_rst_y", bif.bird_y, 240);
        m_y = 240;
        m_v = 0;
        @(negedge clk);
        model_tick(1'b0);
        RESET_GAME = 1'b1;
        repeat (3) @(negedge clk);
        bif.bird_move = 1'b0;
        chk("rel_tick_y", bif.bird_y, REL_FALL_Y);

        apply_reset("rand_rst_y");
        for (int i = 0; i < 200; i++) begin
            do_tick(1'($urandom_range(0, 1)), $urandom_range(4, 8), $urandom_range(1, 6));
        end
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bird_location_unit.md
Name: bird_location_unit

Overview:
- Tracks the player bird's screen position for the Flappy Bird game.
- Sits between the game-tick generator (bird_move) and the renderer/collision logic (bird_x, bird_y).
- Each game tick, the bird moves up while the flap button is held and falls otherwise.
- The position saturates at the playfield limits.

Parameters:
- BIRD_X, 100: fixed horizontal pixel coordinate of the bird.
- Y_START, 240: vertical coordinate loaded on reset.
- Y_MIN, 0: top limit for bird_y.
- Y_MAX, 464: bottom limit for bird_y (480 minus a 16-pixel bird).
- RISE_STEP, 4: pixels moved up per tick while flapping.
- FALL_STEP, 2: pixels moved down per non-flap tick (constant-fall mode).
- GRAVITY, 1: fall-speed increment per tick (gravity mode only).
- MAX_FALL, 8: fall-speed cap (gravity mode only).

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- RESET_GAME, input, 1: asynchronous, active-low reset.
- bird_move, input, 1: game-tick level from the frame/tick generator; its rising edge triggers one movement step.
- KEY, input, 4: board push buttons, active-low. KEY[3] is the flap button; KEY[2:0] are ignored.
- bird_x, output, 11: bird horizontal coordinate.
- bird_y, output, 11: bird vertical coordinate (0 is the top; smaller values are higher on screen).

Behaviour:
- Reset (RESET_GAME=0, asynchronous, takes effect immediately):
  - bird_x=BIRD_X, bird_y=Y_START.
  - Tick-edge register move_q=0.
  - KEY synchroniser stages all 1 (released).
  - Fall velocity=0.
- bird_x is always BIRD_X; it never changes after reset.
- KEY[3] passes through a 2-flop synchroniser. flap = NOT synchronised KEY[3]. A press therefore takes effect 2 clk edges after KEY[3] falls.
- Tick detection:
  - tick = bird_move AND NOT move_q. move_q registers bird_move every cycle.
  - bird_y updates on the same clk edge at which tick is 1, so exactly one step per bird_move rising edge, however long bird_move stays high.
  - If bird_move is high at reset release, the first clk edge counts as a tick.
- On a tick with flap=1:
  - If bird_y < Y_MIN+RISE_STEP, bird_y=Y_MIN; otherwise bird_y -= RISE_STEP.
  - Fall velocity=0.
- On a tick with flap=0 (constant-fall mode):
  - If bird_y+FALL_STEP > Y_MAX, bird_y=Y_MAX; otherwise bird_y += FALL_STEP.
- No tick: all state holds.
- Arithmetic: compare in 12 bits so the 11-bit coordinate never wraps. Outputs are registered with no combinational path from inputs.
- Reset asserted mid-operation overrides everything immediately. The normal tick logic resumes on the first tick after release.

Optional Feature:
- Macro: BIRD_GRAVITY_EN.
- When defined:
  - A 5-bit fall-velocity register is added.
  - On a non-flap tick: vel_next = min(vel+GRAVITY, MAX_FALL), and bird_y += vel_next, saturating at Y_MAX.
  - A flap tick clears the velocity to 0.
  - Reset clears the velocity to 0.
- When undefined: the velocity register is absent and falling uses the constant FALL_STEP. Flap behaviour is identical in both builds.

Test Plan:
- Reset: hold RESET_GAME=0 with bird_move and KEY toggling -> bird_x=100 and bird_y=240 immediately and throughout; release -> values hold until the first tick.
- Flap: KEY[3]=0 held, 3 bird_move rising edges (250 ns low / 250 ns high, 20 ns clk) -> bird_y 240 to 236 to 232 to 228; bird_x stays 100.
- Fall (gravity off): KEY[3]=1, 5 ticks from 240 -> bird_y=250. Gravity on, same stimulus -> velocities 1,2,3,4,5, bird_y=255.
- Top saturation: KEY[3]=0, 65 ticks from 240 -> bird_y reaches 0 at tick 60 and stays 0. Bottom: KEY[3]=1, 150 ticks (gravity off) -> bird_y=464 and holds.
- Edge-only stepping: bird_move held high for 100 clk cycles with KEY[3]=0 -> exactly one step (240 to 236). A 1-cycle KEY[3] release of 10 ns between ticks -> no effect on bird_y.
- Mid-run reset: after bird_y reaches 228, pulse RESET_GAME=0 between clk edges -> bird_y=240 immediately; the next tick after release moves bird_y from 240.
